// File: rtl/code_fetch_unit_if.sv
// Host write port and fetch-to-decode handshake for code_fetch_unit.
// The host side uses the master modport; the fetch unit uses slave.
interface code_fetch_unit_if #(
    parameter int DATA_W = 12
);
    logic              code_storage_write_interface_is_write;
    logic [31:0]       code_storage_write_interface_write_line;
    logic [DATA_W-1:0] code_storage_write_interface_write_data;
    logic              fetch_out_ready;
    logic              fetch_out_valid;
    logic [DATA_W-1:0] fetch_out_code;
    logic [31:0]       fetch_to_decode_register_code_index_out_interface_code_index;

    modport master (
        output code_storage_write_interface_is_write,
        output code_storage_write_interface_write_line,
        output code_storage_write_interface_write_data,
        output fetch_out_ready,
        input  fetch_out_valid,
        input  fetch_out_code,
        input  fetch_to_decode_register_code_index_out_interface_code_index
    );

    modport slave (
        input  code_storage_write_interface_is_write,
        input  code_storage_write_interface_write_line,
        input  code_storage_write_interface_write_data,
        input  fetch_out_ready,
        output fetch_out_valid,
        output fetch_out_code,
        output fetch_to_decode_register_code_index_out_interface_code_index
    );
endinterface

// File: rtl/code_fetch_unit.sv
// Code store plus fetch stage with valid/ready output toward decode.
// Define CODE_FETCH_LOOP_EN to wrap to line 0 instead of finishing.
module code_fetch_unit #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    code_fetch_unit_if.slave  bus,
    input  logic              code_storage_code_control_interface_active,
    input  logic              code_storage_code_control_interface_reset,
    output logic [ADDR_W:0]   program_length,
    output logic              busy,
    output logic              done,
    output logic              write_error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] code_q, code_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] raddr;
    logic [ADDR_W:0]   plen_q, plen_d;
    logic [ADDR_W:0]   wline_p1;
    logic              valid_q, valid_d;
    logic              ok_q, ok_d;
    logic              werr_q, werr_d;
    logic              active, creset;
    logic              hs, last, fin, rd_en;
    logic              wr_req, wr_ok;

    assign active = code_storage_code_control_interface_active;
    assign creset = code_storage_code_control_interface_reset;
    assign wr_req = bus.code_storage_write_interface_is_write;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        ok_d     = ok_q;
        plen_d   = plen_q;
        code_d   = code_q;
        raddr    = idx_q;
        rd_en    = 1'b0;
        fin      = 1'b0;

        hs   = valid_q & bus.fetch_out_ready;
        last = ({1'b0, idx_q} == plen_q - (ADDR_W + 1)'(1));

        wr_ok = wr_req && (state_q != S_RUN) &&
                (bus.code_storage_write_interface_write_line < 32'(DEPTH));
        werr_d = wr_req & ~wr_ok;
        wline_p1 = {1'b0, bus.code_storage_write_interface_write_line[ADDR_W-1:0]}
                   + (ADDR_W + 1)'(1);
        if (wr_ok && (wline_p1 > plen_q))
            plen_d = wline_p1;

        unique case (state_q)
            S_IDLE: begin
                if (active && (plen_q != '0))
                    state_d = S_RUN;
            end
            S_RUN: begin
                if (hs) begin
                    idx_d = idx_q + 1'b1;
                    raddr = idx_q + 1'b1;
                    if (last) begin
`ifdef CODE_FETCH_LOOP_EN
                        idx_d = '0;
                        raddr = '0;
`else
                        fin     = 1'b1;
                        state_d = S_DONE;
`endif
                    end
                end
                // ok_q means code_q already holds line idx_q
                rd_en = active & ~fin;
                if (rd_en)
                    code_d = mem[raddr];
                if (hs)
                    valid_d = rd_en;
                else if (!valid_q)
                    valid_d = ok_q;
                if (rd_en)
                    ok_d = 1'b1;
                else if (hs)
                    ok_d = 1'b0;
            end
            S_DONE: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (creset) begin
            state_d = S_IDLE;
            idx_d   = '0;
            valid_d = 1'b0;
            ok_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ok_q    <= 1'b0;
            plen_q  <= '0;
            werr_q  <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ok_q    <= ok_d;
            plen_q  <= plen_d;
            werr_q  <= werr_d;
            code_q  <= code_d;
        end
    end

    // Storage survives every reset; only the write strobe changes it.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset && wr_ok)
            mem[bus.code_storage_write_interface_write_line[ADDR_W-1:0]]
                <= bus.code_storage_write_interface_write_data;
    end

    assign bus.fetch_out_valid = valid_q;
    assign bus.fetch_out_code  = code_q;
    assign bus.fetch_to_decode_register_code_index_out_interface_code_index =
        32'(idx_q);
    assign program_length = plen_q;
    assign busy           = (state_q == S_RUN);
    assign done           = (state_q == S_DONE);
    assign write_error    = werr_q;

endmodule

// File: tb/tb_code_fetch_unit.sv
// Directed bench for code_fetch_unit: write table, fetch runs,
// backpressure, rejected writes, control reset and hard reset.
module tb_code_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic active = 1'b0;
    logic creset = 1'b0;
    logic [8:0] plen;
    logic busy, done, werr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] prog [4];

    code_fetch_unit_if #(.DATA_W(12)) bus ();

    code_fetch_unit #(.DATA_W(12), .DEPTH(256)) dut (
        .clk_clk                                    (clk),
        .reset_reset                                (rst),
        .bus                                        (bus),
        .code_storage_code_control_interface_active (active),
        .code_storage_code_control_interface_reset  (creset),
        .program_length                             (plen),
        .busy                                       (busy),
        .done                                       (done),
        .write_error                                (werr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] line;
        logic [11:0] data;
        logic        werr_exp;
        logic [8:0]  plen_exp;
    } wvec_t;

    wvec_t wv [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!bus.fetch_out_valid && n < 12) begin
            tick();
            n++;
        end
        check(nm, 32'(bus.fetch_out_valid), 32'd1);
    endtask

    function automatic logic [31:0] idx_out();
        return bus.fetch_to_decode_register_code_index_out_interface_code_index;
    endfunction

    initial begin
        int n_hs;
        int exp_i;
        int cyc;

        prog[0] = 12'h101;
        prog[1] = 12'h202;
        prog[2] = 12'h303;
        prog[3] = 12'h404;

        wv[0] = '{1'b1, 32'd0,         12'h101, 1'b0, 9'd1};
        wv[1] = '{1'b1, 32'd3,         12'h404, 1'b0, 9'd4};
        wv[2] = '{1'b1, 32'd1,         12'h202, 1'b0, 9'd4};
        wv[3] = '{1'b1, 32'd2,         12'h303, 1'b0, 9'd4};
        wv[4] = '{1'b1, 32'd256,       12'hFFF, 1'b1, 9'd4};
        wv[5] = '{1'b1, 32'hFFFF_FFFF, 12'hEEE, 1'b1, 9'd4};
        wv[6] = '{1'b0, 32'd0,         12'h000, 1'b0, 9'd4};

        bus.code_storage_write_interface_is_write   = 1'b0;
        bus.code_storage_write_interface_write_line = '0;
        bus.code_storage_write_interface_write_data = '0;
        bus.fetch_out_ready = 1'b0;

        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", 32'(bus.fetch_out_valid), 0);
        check("rst_code",  32'(bus.fetch_out_code), 0);
        check("rst_index", idx_out(), 0);
        check("rst_plen",  32'(plen), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_done",  32'(done), 0);
        check("rst_werr",  32'(werr), 0);

        for (int i = 0; i < 7; i++) begin
            bus.code_storage_write_interface_is_write   = wv[i].we;
            bus.code_storage_write_interface_write_line = wv[i].line;
            bus.code_storage_write_interface_write_data = wv[i].data;
            tick();
            check($sformatf("wr%0d_werr", i), 32'(werr), 32'(wv[i].werr_exp));
            check($sformatf("wr%0d_plen", i), 32'(plen), 32'(wv[i].plen_exp));
        end
        bus.code_storage_write_interface_is_write = 1'b0;

        // Straight run with ready held high
        active = 1'b1;
        bus.fetch_out_ready = 1'b1;
        tick();
        check("start_busy", 32'(busy), 1);
        check("start_v0", 32'(bus.fetch_out_valid), 0);
        tick();
        check("start_v1", 32'(bus.fetch_out_valid), 0);
        tick();
`ifdef CODE_FETCH_LOOP_EN
        n_hs = 10;
`else
        n_hs = 4;
`endif
        for (int k = 0; k < n_hs; k++) begin
            check($sformatf("run%0d_valid", k), 32'(bus.fetch_out_valid), 1);
            check($sformatf("run%0d_code", k), 32'(bus.fetch_out_code),
                  32'(prog[k % 4]));
            check($sformatf("run%0d_index", k), idx_out(), 32'(k % 4));
            check($sformatf("run%0d_done", k), 32'(done), 0);
            tick();
        end
`ifdef CODE_FETCH_LOOP_EN
        check("loop_done", 32'(done), 0);
        check("loop_busy", 32'(busy), 1);
        check("loop_valid", 32'(bus.fetch_out_valid), 1);
        check("loop_index", idx_out(), 2);
`else
        check("end_done", 32'(done), 1);
        check("end_valid", 32'(bus.fetch_out_valid), 0);
        check("end_busy", 32'(busy), 0);
        tick();
        check("end_hold_done", 32'(done), 1);
`endif

        // Ready toggling: every word held until its handshake
        active = 1'b0;
        creset = 1'b1;
        bus.fetch_out_ready = 1'b0;
        tick();
        creset = 1'b0;
        check("cr_busy", 32'(busy), 0);
        check("cr_done", 32'(done), 0);
        active = 1'b1;
        exp_i = 0;
        cyc = 0;
        while (exp_i < 4 && cyc < 40) begin
            bus.fetch_out_ready = cyc[0];
            if (bus.fetch_out_valid) begin
                check($sformatf("bp%0d_code", cyc), 32'(bus.fetch_out_code),
                      32'(prog[exp_i]));
                check($sformatf("bp%0d_index", cyc), idx_out(), 32'(exp_i));
                if (bus.fetch_out_ready)
                    exp_i++;
            end
            tick();
            cyc++;
        end
        check("bp_count", 32'(exp_i), 4);
`ifndef CODE_FETCH_LOOP_EN
        check("bp_done", 32'(done), 1);
`endif

        // Write while running is rejected
        creset = 1'b1;
        bus.fetch_out_ready = 1'b0;
        tick();
        creset = 1'b0;
        tick();
        check("wrun_busy", 32'(busy), 1);
        bus.code_storage_write_interface_is_write   = 1'b1;
        bus.code_storage_write_interface_write_line = 32'd0;
        bus.code_storage_write_interface_write_data = 12'hABC;
        tick();
        bus.code_storage_write_interface_is_write = 1'b0;
        check("wrun_werr", 32'(werr), 1);
        check("wrun_plen", 32'(plen), 4);
        tick();
        check("wrun_werr_end", 32'(werr), 0);
        wait_valid("wrun_wait");
        check("wrun_code", 32'(bus.fetch_out_code), 32'h101);

        // Control reset at index 2, then restart
        bus.fetch_out_ready = 1'b1;
        cyc = 0;
        while (!(bus.fetch_out_valid && idx_out() == 2) && cyc < 12) begin
            tick();
            cyc++;
        end
        check("mid_reach2", idx_out(), 2);
        creset = 1'b1;
        tick();
        creset = 1'b0;
        check("mid_valid", 32'(bus.fetch_out_valid), 0);
        check("mid_index", idx_out(), 0);
        check("mid_busy", 32'(busy), 0);
        wait_valid("mid_wait");
        check("mid_code", 32'(bus.fetch_out_code), 32'h101);
        check("mid_index2", idx_out(), 0);

        // Hard reset mid-run
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("hr_valid", 32'(bus.fetch_out_valid), 0);
        check("hr_code",  32'(bus.fetch_out_code), 0);
        check("hr_index", idx_out(), 0);
        check("hr_plen",  32'(plen), 0);
        check("hr_busy",  32'(busy), 0);
        check("hr_done",  32'(done), 0);
        check("hr_werr",  32'(werr), 0);
        for (int i = 0; i < 4; i++) tick();
        check("hr_idle_busy", 32'(busy), 0);
        check("hr_idle_valid", 32'(bus.fetch_out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
